// File: rtl/demux_serial_ctrl_pkg.sv
// Shared definitions for the serial-to-demux controller: FSM state encoding,
// frame address width and the default bit period.
package demux_serial_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        ADDR  = 3'd2,
        DATA  = 3'd3,
        STOP  = 3'd4
    } state_t;

    localparam int ADDR_W               = 3;
    localparam int DEFAULT_CLKS_PER_BIT = 4;
    localparam logic [7:0] ERR_CNT_MAX  = 8'hFF;

endpackage

// File: rtl/demux1to8.sv
// Downstream 1-to-8 demultiplexer: routes data bit y onto output line s.
module demux1to8 (
    input  logic [2:0] s,
    input  logic       y,
    output logic [7:0] a
);

    // Drive only the selected line with the data bit; all others stay low.
    always_comb begin
        a    = '0;
        a[s] = y;
    end

endmodule

// File: rtl/sync2.sv
// Two-flop synchronizer for the asynchronous serial line. Both flops reset
// high so a line idling high never looks like a falling edge at reset release.
module sync2 (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    // Double-register the asynchronous input into the clk domain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b1;
            q    <= 1'b1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/demux_serial_ctrl.sv
// Serial frame receiver that drives the select and data inputs of a 1-to-8
// demultiplexer. A frame is start(0), 3 address bits LSB first, 1 data bit
// and stop(1); each bit lasts CLKS_PER_BIT clocks. Good frames update s/y,
// bad stop bits pulse frame_err and bump a saturating error counter.
module demux_serial_ctrl
    import demux_serial_ctrl_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic [3:0] s,
    output logic       y,
    output logic       frame_done,
    output logic       frame_err,
    output logic [7:0] err_cnt
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] HALF_BIT = CNT_W'(CLKS_PER_BIT / 2);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [1:0]       LAST_ADDR_BIT = 2'(ADDR_W - 1);

    state_t              state, state_next;
    logic [CNT_W-1:0]    cnt, cnt_next;
    logic [1:0]          bit_idx, bit_next;
    logic [ADDR_W-1:0]   addr, addr_next;
    logic                data_bit, data_next;
    logic                rx_s;
    logic                rx_d;
    logic                good_stop;
    logic                bad_stop;

    sync2 u_sync2 (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (rx),
        .q     (rx_s)
    );

    // State register; reset drops any partial frame back to IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and sampling decisions. The bit counter wraps to zero at
    // every sample point, so later samples land one full bit period apart.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        bit_next   = bit_idx;
        addr_next  = addr;
        data_next  = data_bit;
        good_stop  = 1'b0;
        bad_stop   = 1'b0;

        case (state)
            IDLE: begin
                cnt_next = '0;
                bit_next = '0;
                if (rx_d && !rx_s) begin
                    state_next = START;
                end
            end

            START: begin
                if (cnt == HALF_BIT) begin
                    cnt_next   = '0;
                    state_next = rx_s ? IDLE : ADDR;
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end

            ADDR: begin
                if (cnt == LAST_CNT) begin
                    cnt_next  = '0;
                    addr_next = {rx_s, addr[ADDR_W-1:1]};
                    if (bit_idx == LAST_ADDR_BIT) begin
                        bit_next   = '0;
                        state_next = DATA;
                    end else begin
                        bit_next = bit_idx + 2'd1;
                    end
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end

            DATA: begin
                if (cnt == LAST_CNT) begin
                    cnt_next   = '0;
                    data_next  = rx_s;
                    state_next = STOP;
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end

            STOP: begin
                if (cnt == LAST_CNT) begin
                    cnt_next   = '0;
                    state_next = IDLE;
                    if (rx_s) begin
                        good_stop = 1'b1;
                    end else begin
                        bad_stop = 1'b1;
                    end
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end

            default: begin
                state_next = IDLE;
                cnt_next   = '0;
                bit_next   = '0;
            end
        endcase
    end

    // Frame datapath: bit counter, address shift register, data bit and the
    // previous synchronized line level used for falling-edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt      <= '0;
            bit_idx  <= '0;
            addr     <= '0;
            data_bit <= 1'b0;
            rx_d     <= 1'b1;
        end else begin
            cnt      <= cnt_next;
            bit_idx  <= bit_next;
            addr     <= addr_next;
            data_bit <= data_next;
            rx_d     <= rx_s;
        end
    end

    // Output registers: s/y load only on a good stop bit, pulses last one
    // cycle, and the error counter sticks at its maximum.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s          <= '0;
            y          <= 1'b0;
            frame_done <= 1'b0;
            frame_err  <= 1'b0;
            err_cnt    <= '0;
        end else begin
            frame_done <= good_stop;
            frame_err  <= bad_stop;
            if (good_stop) begin
                s <= {1'b0, addr};
                y <= data_bit;
            end
            if (bad_stop && (err_cnt != ERR_CNT_MAX)) begin
                err_cnt <= err_cnt + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_demux_serial_ctrl.sv
// Self-checking bench for demux_serial_ctrl feeding demux1to8 at
// CLKS_PER_BIT = 4. A frame-level model tracks the expected s, y, error
// count and pulse totals; a monitor counts pulses seen on the DUT.
module tb_demux_serial_ctrl;

    localparam int CPB = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx = 1'b1;
    logic [3:0] s;
    logic       y;
    logic       frame_done;
    logic       frame_err;
    logic [7:0] err_cnt;
    logic [7:0] a;

    int vectors = 0;
    int miscompares = 0;

    // Frame-level reference model state.
    logic [3:0] exp_s = 4'd0;
    logic       exp_y = 1'b0;
    int         exp_err = 0;
    int         exp_done = 0;
    int         exp_errp = 0;

    // Monitor observations.
    int         done_seen = 0;
    int         err_seen = 0;
    int         both_seen = 0;
    logic [3:0] done_q[$];

    demux_serial_ctrl #(.CLKS_PER_BIT(CPB)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx         (rx),
        .s          (s),
        .y          (y),
        .frame_done (frame_done),
        .frame_err  (frame_err),
        .err_cnt    (err_cnt)
    );

    demux1to8 u_demux (
        .s (s[2:0]),
        .y (y),
        .a (a)
    );

    // Free-running clock, 10 time units per period.
    always #5 clk = ~clk;

    // Count pulses on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (frame_done && frame_err) both_seen++;
        if (frame_done) begin
            done_seen++;
            done_q.push_back(s);
        end
        if (frame_err) err_seen++;
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drive_bit(input logic b);
        rx = b;
        step(CPB);
    endtask

    task automatic idle(input int n);
        rx = 1'b1;
        step(n);
    endtask

    task automatic send_frame(input logic [2:0] fa, input logic fd, input logic fs);
        logic [5:0] bits;
        bits = {fs, fd, fa, 1'b0};
        for (int i = 0; i < 6; i++) drive_bit(bits[i]);
    endtask

    // Reference model: what one complete frame does to the outputs.
    task automatic model_frame(input logic [2:0] fa, input logic fd, input logic fs);
        if (fs) begin
            exp_s = {1'b0, fa};
            exp_y = fd;
            exp_done++;
        end else begin
            exp_errp++;
            if (exp_err < 255) exp_err++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        rx    = 1'b1;
        step(3);
        vectors++;
        if ({s, y, frame_done, frame_err, err_cnt} !== 15'd0) begin
            miscompares++;
            $display("[TB] FAIL reset_state: s=%b y=%b done=%b err=%b cnt=%0d, required all 0",
                     s, y, frame_done, frame_err, err_cnt);
        end
        rst_n = 1'b1;
        idle(5);
    endtask

    task automatic test_good_frame();
        send_frame(3'b101, 1'b1, 1'b1);
        model_frame(3'b101, 1'b1, 1'b1);
        idle(6);
        vectors++;
        if (s !== 4'b0101 || y !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL good_frame_sy: s=%b y=%b, required s=0101 y=1", s, y);
        end
        vectors++;
        if (a !== 8'b0010_0000) begin
            miscompares++;
            $display("[TB] FAIL good_frame_demux: a=%b, required 00100000", a);
        end
        vectors++;
        if (done_seen !== 1 || err_seen !== 0) begin
            miscompares++;
            $display("[TB] FAIL good_frame_pulses: done=%0d err=%0d, required 1/0", done_seen, err_seen);
        end
    endtask

    task automatic test_framing_error();
        send_frame(3'b011, 1'b1, 1'b0);
        model_frame(3'b011, 1'b1, 1'b0);
        idle(6);
        vectors++;
        if (err_seen !== exp_errp || err_cnt !== 8'd1) begin
            miscompares++;
            $display("[TB] FAIL framing_error: pulses=%0d cnt=%0d, required %0d/1", err_seen, err_cnt, exp_errp);
        end
        vectors++;
        if (s !== 4'b0101 || y !== 1'b1 || done_seen !== exp_done) begin
            miscompares++;
            $display("[TB] FAIL framing_error_hold: s=%b y=%b done=%0d, required 0101/1/%0d",
                     s, y, done_seen, exp_done);
        end
    endtask

    task automatic test_start_glitch();
        rx = 1'b0;
        step(1);
        idle(12);
        vectors++;
        if (done_seen !== exp_done || err_seen !== exp_errp || s !== exp_s || y !== exp_y) begin
            miscompares++;
            $display("[TB] FAIL start_glitch: done=%0d err=%0d s=%b y=%b, required %0d/%0d/%b/%b",
                     done_seen, err_seen, s, y, exp_done, exp_errp, exp_s, exp_y);
        end
        send_frame(3'd6, 1'b0, 1'b1);
        model_frame(3'd6, 1'b0, 1'b1);
        idle(6);
        vectors++;
        if (s !== exp_s || y !== exp_y || done_seen !== exp_done) begin
            miscompares++;
            $display("[TB] FAIL glitch_recover: s=%b y=%b done=%0d, required %b/%b/%0d",
                     s, y, done_seen, exp_s, exp_y, exp_done);
        end
    endtask

    task automatic test_back_to_back();
        done_q.delete();
        for (int i = 0; i < 8; i++) begin
            send_frame(3'(i), 1'b1, 1'b1);
            model_frame(3'(i), 1'b1, 1'b1);
        end
        idle(6);
        vectors++;
        if (done_q.size() !== 8 || done_seen !== exp_done) begin
            miscompares++;
            $display("[TB] FAIL sweep_count: pulses=%0d total=%0d, required 8/%0d",
                     done_q.size(), done_seen, exp_done);
        end
        for (int i = 0; i < 8 && i < done_q.size(); i++) begin
            vectors++;
            if (done_q[i] !== 4'(i)) begin
                miscompares++;
                $display("[TB] FAIL sweep_step%0d: s=%b, required %b", i, done_q[i], 4'(i));
            end
        end
        vectors++;
        if (a !== 8'b1000_0000) begin
            miscompares++;
            $display("[TB] FAIL sweep_demux: a=%b, required 10000000", a);
        end
    endtask

    task automatic test_random();
        logic [2:0] fa;
        logic       fd;
        logic       fs;
        logic [7:0] exp_a;
        for (int n = 0; n < 40; n++) begin
            fa = 3'($urandom_range(0, 7));
            fd = 1'($urandom_range(0, 1));
            fs = ($urandom_range(0, 3) != 0);
            send_frame(fa, fd, fs);
            model_frame(fa, fd, fs);
            idle($urandom_range(6, 9));
            exp_a = exp_y ? (8'd1 << exp_s[2:0]) : 8'd0;
            vectors++;
            if (s !== exp_s || y !== exp_y || a !== exp_a || err_cnt !== 8'(exp_err)
                || done_seen !== exp_done || err_seen !== exp_errp) begin
                miscompares++;
                $display("[TB] FAIL random%0d: s=%b y=%b a=%b cnt=%0d done=%0d err=%0d, required %b/%b/%b/%0d/%0d/%0d",
                         n, s, y, a, err_cnt, done_seen, err_seen,
                         exp_s, exp_y, exp_a, exp_err, exp_done, exp_errp);
            end
        end
    endtask

    task automatic test_mid_frame_reset();
        logic [2:0] pa;
        send_frame(3'd7, 1'b1, 1'b1);
        model_frame(3'd7, 1'b1, 1'b1);
        idle(6);
        pa = 3'b010;
        drive_bit(1'b0);
        for (int i = 0; i < 3; i++) drive_bit(pa[i]);
        rx = 1'b1;
        step(3);
        rst_n = 1'b0;
        #1;
        exp_s   = 4'd0;
        exp_y   = 1'b0;
        exp_err = 0;
        vectors++;
        if ({s, y, frame_done, frame_err, err_cnt} !== 15'd0) begin
            miscompares++;
            $display("[TB] FAIL midframe_reset: s=%b y=%b done=%b err=%b cnt=%0d, required all 0",
                     s, y, frame_done, frame_err, err_cnt);
        end
        rx = 1'b1;
        step(3);
        rst_n = 1'b1;
        idle(40);
        vectors++;
        if (done_seen !== exp_done || err_seen !== exp_errp || s !== 4'd0 || y !== 1'b0 || err_cnt !== 8'd0) begin
            miscompares++;
            $display("[TB] FAIL post_reset: done=%0d err=%0d s=%b y=%b cnt=%0d, required %0d/%0d/0000/0/0",
                     done_seen, err_seen, s, y, err_cnt, exp_done, exp_errp);
        end
    endtask

    task automatic test_saturation();
        for (int n = 0; n < 260; n++) begin
            send_frame(3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 1'b0);
            model_frame(3'd0, 1'b0, 1'b0);
            idle(4);
            vectors++;
            if (err_cnt !== 8'(exp_err)) begin
                miscompares++;
                $display("[TB] FAIL saturation%0d: err_cnt=%0d, required %0d", n, err_cnt, exp_err);
            end
        end
        vectors++;
        if (err_cnt !== 8'd255 || err_seen !== exp_errp || s !== 4'd0 || y !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL saturation_final: cnt=%0d pulses=%0d s=%b y=%b, required 255/%0d/0000/0",
                     err_cnt, err_seen, s, y, exp_errp);
        end
    endtask

    task automatic test_exclusive_pulses();
        vectors++;
        if (both_seen !== 0) begin
            miscompares++;
            $display("[TB] FAIL exclusive_pulses: overlap cycles=%0d, required 0", both_seen);
        end
    endtask

    initial begin
        test_reset();
        test_good_frame();
        test_framing_error();
        test_start_glitch();
        test_back_to_back();
        test_random();
        test_mid_frame_reset();
        test_saturation();
        test_exclusive_pulses();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
